vga_menu_renderer: RTL and testbench
====================================

# vga_menu_renderer

Parametrised successor to the fixed three/five-option main-menu pixel processor. Renders a logo plus a grid of NUM_ROWS × NUM_COLS text options, drawn from a run-time label bus, on the VGA pixel-address stream. It owns the menu selection state machine (directional keys, wrap-around, confirm) and draws a blinking selection box. It sits between the VGA address generator, the image/glyph ROM and the palette lookup, with a fixed 3-cycle pipeline latency.

## Interface
Parameters:
- NUM_ROWS, 3, option rows.
- NUM_COLS, 2, option columns.
- NUM_CHARS, 7, characters per label.
- CHAR_W / CHAR_H, 21 / 25, glyph size in pixels.
- COL_X0 / COL_PITCH, 133 / 227, x of column 0 text; column spacing.
- ROW_Y0 / ROW_PITCH, 227 / 58, y of row 0 text; row spacing.
- GLYPH_BASE, 307200, ROM address of glyph 0; glyph g starts at GLYPH_BASE + 525·g.
- LOGO_BASE, 25940; LOGO_X0/LOGO_Y0, 204/40; LOGO_W/LOGO_H, 231/156.
- BLANK_ADDR, 1923, ROM address for background.
- BOX_COLOR, 7, palette index for border and selection box.
- BLINK_FRAMES, 30, frames per blink half-period.

Ports:
- clock  in  1  pixel clock.
- resetn  in  1  asynchronous, active-low reset.
- curAddress  in  19  pixel address, y·640+x, 0..307199.
- addrValid  in  1  curAddress is valid this cycle.
- labels  in  NUM_ROWS·NUM_COLS·NUM_CHARS·6  glyph codes; option o = r·NUM_COLS+c, char k at bits [6(o·NUM_CHARS+k)+:6]; code 63 = space.
- numOpts  in  8  enabled options, 1..NUM_ROWS·NUM_COLS; options ≥ numOpts are hidden and unselectable.
- keyUp, keyDown, keyLeft, keyRight, keyConfirm  in  1 each  single-cycle key pulses.
- addrToRead  out  19  ROM address, registered.
- indexIn  in  8  ROM data, valid 1 cycle after addrToRead.
- indexOut  out  8  final palette index, registered.
- indexValid  out  1  indexOut valid.
- selIndex  out  8  selected option o.
- chosen  out  1  one-cycle pulse on confirm; selIndex is stable during it.

## Operation
- Stage 1: x,y are derived via addr_to_cart. Priority: logo window → LOGO_BASE + (x−LOGO_X0) + 640(y−LOGO_Y0); else an enabled option text cell → GLYPH_BASE + 525·g + (x−cellX) + 21(y−cellY); space or any other pixel → BLANK_ADDR. Cell k of option (r,c) spans x ∈ [COL_X0+c·COL_PITCH+k·CHAR_W, +CHAR_W) and y ∈ [ROW_Y0+r·ROW_PITCH, +CHAR_H). All arithmetic is 19-bit unsigned.
- Stage 2: x, y and addrValid are delayed to align with indexIn.
- Stage 3: outputs BOX_COLOR if x<3, x>636, y<3 or y>476. Otherwise outputs BOX_COLOR on the selection box while the box is visible: a 3-px frame spanning x ∈ [cellX0−3, cellX0+150), y ∈ [cellY0−3, cellY0+28). Otherwise outputs indexIn.
- Selection state: selRow and selCol registers.
  - Up/Down: decrement/increment selRow modulo NUM_ROWS.
  - Left/Right: the same on selCol, modulo NUM_COLS.
  - Key priority: Confirm > Up > Down > Left > Right. Only one action per cycle.
  - Skipping: if the target option is disabled, keep stepping in the same direction until an enabled option is found. If none exists, stay put.
  - numOpts change: if the current option becomes disabled, force the selection to 0.
- Blink FSM: states SHOW and HIDE.
  - End of frame is curAddress=307199 with addrValid high. On each end of frame a frame counter increments.
  - When the counter reaches BLINK_FRAMES−1 it clears and the FSM toggles state.
  - Any move forces SHOW and clears the counter.

## Timing
- Latency: curAddress at cycle t → addrToRead at t+1 → indexIn at t+2 → indexOut/indexValid at t+3. Full throughput, one pixel per clock.
- A selection change takes effect in stage 3 from the next clock edge. It may change mid-frame.
- chosen is asserted in the cycle after keyConfirm.
- Reset values:
  - addrToRead=BLANK_ADDR, indexOut=0, indexValid=0, chosen=0.
  - selIndex=0 (selRow=selCol=0).
  - Blink state SHOW, frame counter 0, pipeline valids 0.
- Reset mid-frame: the pipeline flushes, and indexValid stays low until 3 cycles after the first valid address.

## Test plan
- Pixel (204,40) → addrToRead=25940. Pixel (134,228) with option 0 char 0 = 25 → 307200+13125+1+21 = 320347. indexOut is present 3 cycles later.
- Label code 63 at option 1 char 4 → BLANK_ADDR across that cell. Pixel (5,1) → indexOut=7 regardless of indexIn.
- numOpts=5, selection 0 → keyUp lands on option 4 (r2,c0). keyRight from option 4 skips disabled option 5 and lands on option 4 (no move). keyDown then keyDown from option 0 → option 4.
- keyConfirm and keyDown in the same cycle → chosen=1 with selIndex unchanged; no move.
- Feed 30 end-of-frame strobes → box pixel (130,224) reads indexIn (HIDE). A keyLeft then immediately returns BOX_COLOR.
- Assert resetn low mid-line → all outputs take reset values asynchronously. The first indexValid appears 3 clocks after addrValid resumes.

Source files
------------

// File: rtl/vga_menu_renderer.sv
`timescale 1ns/1ps
// Menu pixel processor: logo, a grid of option labels, a border and a blinking selection box on the VGA address stream.
// Latency: fixed 3 cycles from curAddress to indexOut/indexValid. It accepts one pixel per clock.
// Backpressure: none. The pixel stream is never stalled, and keys are single-cycle pulses that are acted on the cycle they arrive.
module vga_menu_renderer #(
    parameter int NUM_ROWS     = 3,
    parameter int NUM_COLS     = 2,
    parameter int NUM_CHARS    = 7,
    parameter int CHAR_W       = 21,
    parameter int CHAR_H       = 25,
    parameter int COL_X0       = 133,
    parameter int COL_PITCH    = 227,
    parameter int ROW_Y0       = 227,
    parameter int ROW_PITCH    = 58,
    parameter int GLYPH_BASE   = 307200,
    parameter int LOGO_BASE    = 25940,
    parameter int LOGO_X0      = 204,
    parameter int LOGO_Y0      = 40,
    parameter int LOGO_W       = 231,
    parameter int LOGO_H       = 156,
    parameter int BLANK_ADDR   = 1923,
    parameter int BOX_COLOR    = 7,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic [18:0]                           curAddress,
    input  logic                                  addrValid,
    input  logic [NUM_ROWS*NUM_COLS*NUM_CHARS*6-1:0] labels,
    input  logic [7:0]                            numOpts,
    input  logic                                  keyUp,
    input  logic                                  keyDown,
    input  logic                                  keyLeft,
    input  logic                                  keyRight,
    input  logic                                  keyConfirm,
    output logic [18:0]                           addrToRead,
    input  logic [7:0]                            indexIn,
    output logic [7:0]                            indexOut,
    output logic                                  indexValid,
    output logic [7:0]                            selIndex,
    output logic                                  chosen
);

    localparam int RW         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int CW         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TEXT_W     = NUM_CHARS * CHAR_W;
    localparam int BOX_T      = 3;
    localparam int GLYPH_SIZE = CHAR_W * CHAR_H;
    localparam logic [18:0] LAST_PIXEL = 19'd307199;
    localparam logic [5:0]  SPACE_CODE = 6'd63;

    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} blink_t;

    // Split a linear pixel address into screen coordinates.
    function automatic void addr_to_cart(input logic [18:0] a, output logic [18:0] x, output logic [18:0] y);
        y = a / 19'd640;
        x = a - y * 19'd640;
    endfunction

    // An option counts as enabled when its linear index is below numOpts.
    function automatic logic opt_enabled(input int r, input int c, input logic [7:0] n);
        return (r * NUM_COLS + c) < int'({24'd0, n});
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: coordinates and ROM address
    // ------------------------------------------------------------------
    logic [18:0] px0, py0;
    logic [18:0] rd_addr;
    logic [18:0] cell_x, cell_y;
    logic [5:0]  glyph;
    logic        text_hit;

    logic [18:0] x1, y1, x2, y2;
    logic        v1, v2;

    // Decode the pixel to a logo, glyph or background ROM address.
    always_comb begin
        addr_to_cart(curAddress, px0, py0);
        rd_addr  = 19'(BLANK_ADDR);
        cell_x   = '0;
        cell_y   = '0;
        glyph    = SPACE_CODE;
        text_hit = 1'b0;
        if (px0 >= 19'(LOGO_X0) && px0 < 19'(LOGO_X0 + LOGO_W) &&
            py0 >= 19'(LOGO_Y0) && py0 < 19'(LOGO_Y0 + LOGO_H)) begin
            rd_addr = 19'(LOGO_BASE) + (px0 - 19'(LOGO_X0)) + 19'd640 * (py0 - 19'(LOGO_Y0));
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                for (int c = 0; c < NUM_COLS; c++) begin
                    for (int k = 0; k < NUM_CHARS; k++) begin
                        if (!text_hit && opt_enabled(r, c, numOpts) &&
                            px0 >= 19'(COL_X0 + c * COL_PITCH + k * CHAR_W) &&
                            px0 <  19'(COL_X0 + c * COL_PITCH + (k + 1) * CHAR_W) &&
                            py0 >= 19'(ROW_Y0 + r * ROW_PITCH) &&
                            py0 <  19'(ROW_Y0 + r * ROW_PITCH + CHAR_H)) begin
                            text_hit = 1'b1;
                            cell_x   = 19'(COL_X0 + c * COL_PITCH + k * CHAR_W);
                            cell_y   = 19'(ROW_Y0 + r * ROW_PITCH);
                            glyph    = labels[6 * ((r * NUM_COLS + c) * NUM_CHARS + k) +: 6];
                        end
                    end
                end
            end
            // A space glyph falls through to the background address.
            if (text_hit && glyph != SPACE_CODE) begin
                rd_addr = 19'(GLYPH_BASE) + 19'(GLYPH_SIZE) * {13'd0, glyph}
                        + (px0 - cell_x) + 19'(CHAR_W) * (py0 - cell_y);
            end
        end
    end

    // Register the ROM address and carry coordinates alongside it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addrToRead <= 19'(BLANK_ADDR);
            x1         <= '0;
            y1         <= '0;
            v1         <= 1'b0;
        end else begin
            addrToRead <= rd_addr;
            x1         <= px0;
            y1         <= py0;
            v1         <= addrValid;
        end
    end

    // Stage 2: hold coordinates while the ROM produces indexIn.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x2 <= '0;
            y2 <= '0;
            v2 <= 1'b0;
        end else begin
            x2 <= x1;
            y2 <= y1;
            v2 <= v1;
        end
    end

    // ------------------------------------------------------------------
    // Selection state
    // ------------------------------------------------------------------
    logic [RW-1:0] sel_row, nxt_row;
    logic [CW-1:0] sel_col, nxt_col;
    logic          moved;

    // Work out the next selection. Confirm wins, and disabled options are stepped over.
    always_comb begin
        nxt_row = sel_row;
        nxt_col = sel_col;
        moved   = 1'b0;
        if (!opt_enabled(int'(sel_row), int'(sel_col), numOpts)) begin
            nxt_row = '0;
            nxt_col = '0;
        end else if (keyConfirm) begin
            nxt_row = sel_row;
        end else if (keyUp) begin
            for (int s = 1; s < NUM_ROWS; s++) begin
                if (!moved && opt_enabled((int'(sel_row) + NUM_ROWS - s) % NUM_ROWS, int'(sel_col), numOpts)) begin
                    moved   = 1'b1;
                    nxt_row = RW'((int'(sel_row) + NUM_ROWS - s) % NUM_ROWS);
                end
            end
        end else if (keyDown) begin
            for (int s = 1; s < NUM_ROWS; s++) begin
                if (!moved && opt_enabled((int'(sel_row) + s) % NUM_ROWS, int'(sel_col), numOpts)) begin
                    moved   = 1'b1;
                    nxt_row = RW'((int'(sel_row) + s) % NUM_ROWS);
                end
            end
        end else if (keyLeft) begin
            for (int s = 1; s < NUM_COLS; s++) begin
                if (!moved && opt_enabled(int'(sel_row), (int'(sel_col) + NUM_COLS - s) % NUM_COLS, numOpts)) begin
                    moved   = 1'b1;
                    nxt_col = CW'((int'(sel_col) + NUM_COLS - s) % NUM_COLS);
                end
            end
        end else if (keyRight) begin
            for (int s = 1; s < NUM_COLS; s++) begin
                if (!moved && opt_enabled(int'(sel_row), (int'(sel_col) + s) % NUM_COLS, numOpts)) begin
                    moved   = 1'b1;
                    nxt_col = CW'((int'(sel_col) + s) % NUM_COLS);
                end
            end
        end
    end

    // Selection registers and the registered confirm pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sel_row <= '0;
            sel_col <= '0;
            chosen  <= 1'b0;
        end else begin
            sel_row <= nxt_row;
            sel_col <= nxt_col;
            chosen  <= keyConfirm;
        end
    end

    // The selected option is reported as a linear option index.
    always_comb begin
        selIndex = 8'(int'(sel_row) * NUM_COLS + int'(sel_col));
    end

    // ------------------------------------------------------------------
    // Blink FSM
    // ------------------------------------------------------------------
    blink_t        blink_state, nxt_blink;
    logic [FW-1:0] frame_cnt, nxt_cnt;
    logic          end_of_frame;
    logic          box_vis;

    // Blink state and frame counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_state <= SHOW;
            frame_cnt   <= '0;
        end else begin
            blink_state <= nxt_blink;
            frame_cnt   <= nxt_cnt;
        end
    end

    // Count frames and toggle every BLINK_FRAMES. A move restarts the SHOW half.
    always_comb begin
        end_of_frame = addrValid && (curAddress == LAST_PIXEL);
        nxt_blink    = blink_state;
        nxt_cnt      = frame_cnt;
        if (moved) begin
            nxt_blink = SHOW;
            nxt_cnt   = '0;
        end else if (end_of_frame) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                nxt_cnt   = '0;
                nxt_blink = (blink_state == SHOW) ? HIDE : SHOW;
            end else begin
                nxt_cnt = frame_cnt + 1'b1;
            end
        end
    end

    // The selection box is drawn only during the SHOW half-period.
    always_comb begin
        box_vis = (blink_state == SHOW);
    end

    // ------------------------------------------------------------------
    // Stage 3: overlay border and selection box on ROM data
    // ------------------------------------------------------------------
    logic [18:0] box_x0, box_y0;
    logic        on_border, in_outer, in_inner;
    logic [7:0]  pix_out;

    // Pick BOX_COLOR on the border or a visible box frame, else pass the ROM data through.
    always_comb begin
        box_x0    = 19'(COL_X0 + int'(sel_col) * COL_PITCH);
        box_y0    = 19'(ROW_Y0 + int'(sel_row) * ROW_PITCH);
        on_border = (x2 < 19'd3) || (x2 > 19'd636) || (y2 < 19'd3) || (y2 > 19'd476);
        in_outer  = (x2 >= box_x0 - 19'(BOX_T)) && (x2 < box_x0 + 19'(TEXT_W + BOX_T)) &&
                    (y2 >= box_y0 - 19'(BOX_T)) && (y2 < box_y0 + 19'(CHAR_H + BOX_T));
        in_inner  = (x2 >= box_x0) && (x2 < box_x0 + 19'(TEXT_W)) &&
                    (y2 >= box_y0) && (y2 < box_y0 + 19'(CHAR_H));
        if (on_border || (box_vis && in_outer && !in_inner)) begin
            pix_out = 8'(BOX_COLOR);
        end else begin
            pix_out = indexIn;
        end
    end

    // Output register. The last pixel is held while the stream is idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            indexOut   <= '0;
            indexValid <= 1'b0;
        end else begin
            indexValid <= v2;
            if (v2) begin
                indexOut <= pix_out;
            end
        end
    end

endmodule

// File: tb/tb_vga_menu_renderer.sv
`timescale 1ns/1ps
module tb_vga_menu_renderer;

    logic         clock;
    logic         resetn;
    logic [18:0]  curAddress;
    logic         addrValid;
    logic [251:0] labels;
    logic [7:0]   numOpts;
    logic         keyUp, keyDown, keyLeft, keyRight, keyConfirm;
    logic [18:0]  addrToRead;
    logic [7:0]   indexIn;
    logic [7:0]   indexOut;
    logic         indexValid;
    logic [7:0]   selIndex;
    logic         chosen;

    int tests  = 0;
    int failed = 0;

    vga_menu_renderer dut (
        .clock      (clock),
        .resetn     (resetn),
        .curAddress (curAddress),
        .addrValid  (addrValid),
        .labels     (labels),
        .numOpts    (numOpts),
        .keyUp      (keyUp),
        .keyDown    (keyDown),
        .keyLeft    (keyLeft),
        .keyRight   (keyRight),
        .keyConfirm (keyConfirm),
        .addrToRead (addrToRead),
        .indexIn    (indexIn),
        .indexOut   (indexOut),
        .indexValid (indexValid),
        .selIndex   (selIndex),
        .chosen     (chosen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated pixel through the pipe. The ROM data is only correct in the cycle that stage 3 samples it.
    task automatic run_pixel(input string tag, input int x, input int y, input logic [7:0] din,
                             input logic [18:0] exp_addr, input logic [7:0] exp_out);
        @(negedge clock);
        curAddress = 19'(y * 640 + x);
        addrValid  = 1'b1;
        indexIn    = 8'hEE;
        @(posedge clock); #1;
        check({tag, ".addr"}, 32'(addrToRead), 32'(exp_addr));
        addrValid = 1'b0;
        @(posedge clock); #1;
        check({tag, ".vld_early"}, 32'(indexValid), 32'd0);
        indexIn = din;
        @(posedge clock); #1;
        check({tag, ".vld"}, 32'(indexValid), 32'd1);
        check({tag, ".out"}, 32'(indexOut), 32'(exp_out));
        indexIn = 8'hEE;
    endtask

    task automatic press(input logic c, input logic u, input logic d, input logic l, input logic r);
        @(negedge clock);
        keyConfirm = c; keyUp = u; keyDown = d; keyLeft = l; keyRight = r;
        @(posedge clock); #1;
        keyConfirm = 0; keyUp = 0; keyDown = 0; keyLeft = 0; keyRight = 0;
    endtask

    initial begin
        resetn = 1'b0;
        curAddress = '0; addrValid = 1'b0; indexIn = 8'hEE;
        keyUp = 0; keyDown = 0; keyLeft = 0; keyRight = 0; keyConfirm = 0;
        numOpts = 8'd6;
        labels = '1;
        labels[5:0]   = 6'd25;
        labels[47:42] = 6'd10;
        #12;
        check("rst.addr", 32'(addrToRead), 32'd1923);
        check("rst.out", 32'(indexOut), 32'd0);
        check("rst.vld", 32'(indexValid), 32'd0);
        check("rst.chosen", 32'(chosen), 32'd0);
        check("rst.sel", 32'(selIndex), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        run_pixel("logo", 204, 40, 8'h3C, 19'd25940, 8'h3C);
        run_pixel("glyph25", 134, 228, 8'h5A, 19'd320347, 8'h5A);
        run_pixel("space", 450, 230, 8'h61, 19'd1923, 8'h61);
        run_pixel("glyph10", 361, 229, 8'h62, 19'd312493, 8'h62);
        run_pixel("border", 5, 1, 8'h11, 19'd1923, 8'd7);
        run_pixel("box_show", 130, 224, 8'h22, 19'd1923, 8'd7);

        @(negedge clock); numOpts = 8'd1;
        run_pixel("hidden_opt", 361, 229, 8'h63, 19'd1923, 8'h63);

        @(negedge clock); numOpts = 8'd5;
        press(0, 1, 0, 0, 0);
        check("up_wrap", 32'(selIndex), 32'd4);
        press(0, 0, 0, 0, 1);
        check("right_skip", 32'(selIndex), 32'd4);
        press(0, 0, 1, 0, 0);
        check("down_wrap", 32'(selIndex), 32'd0);
        press(0, 0, 1, 0, 0);
        check("down1", 32'(selIndex), 32'd2);
        press(0, 0, 1, 0, 0);
        check("down2", 32'(selIndex), 32'd4);

        @(negedge clock); numOpts = 8'd3;
        @(posedge clock); #1;
        check("force_zero", 32'(selIndex), 32'd0);

        @(negedge clock); numOpts = 8'd6;
        press(1, 0, 1, 0, 0);
        check("confirm.chosen", 32'(chosen), 32'd1);
        check("confirm.sel", 32'(selIndex), 32'd0);
        @(posedge clock); #1;
        check("confirm.pulse_end", 32'(chosen), 32'd0);

        @(negedge clock);
        curAddress = 19'd307199;
        addrValid  = 1'b1;
        repeat (30) @(negedge clock);
        addrValid  = 1'b0;
        run_pixel("box_hide", 130, 224, 8'h33, 19'd1923, 8'h33);
        run_pixel("border_hide", 5, 1, 8'h34, 19'd1923, 8'd7);

        press(0, 0, 0, 1, 0);
        check("left_wrap", 32'(selIndex), 32'd1);
        run_pixel("box_moved", 357, 224, 8'h44, 19'd1923, 8'd7);
        run_pixel("box_old", 130, 224, 8'h45, 19'd1923, 8'h45);

        @(negedge clock);
        curAddress = 19'(300 * 640 + 100);
        addrValid  = 1'b1;
        repeat (4) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("arst.addr", 32'(addrToRead), 32'd1923);
        check("arst.out", 32'(indexOut), 32'd0);
        check("arst.vld", 32'(indexValid), 32'd0);
        check("arst.sel", 32'(selIndex), 32'd0);
        check("arst.chosen", 32'(chosen), 32'd0);
        addrValid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        addrValid = 1'b1;
        @(posedge clock); #1;
        check("resume.c1", 32'(indexValid), 32'd0);
        @(posedge clock); #1;
        check("resume.c2", 32'(indexValid), 32'd0);
        @(posedge clock); #1;
        check("resume.c3", 32'(indexValid), 32'd1);
        addrValid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
